// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit write-only sequencer.
// Accepts command/data bytes over valid/ready, sends each as two nibbles
// with E setup/width/hold timing, waits the LCD execution time, and runs
// the power-on 4-bit init sequence on its own when INIT_EN is set.
module lcd_hd44780_ctrl #(
    parameter bit INIT_EN = 1'b1,
    parameter int T_AS    = 2,
    parameter int T_EPW   = 13,
    parameter int T_H     = 2,
    parameter int T_NIB   = 27,
    parameter int T_EXEC  = 1080,
    parameter int T_LONG  = 44550,
    parameter int T_PWRON = 432000,
    parameter int T_INIT2 = 118800,
    parameter int T_INIT3 = 2970,
    parameter int TW      = 20
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [3:0] lcd_db
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        IDLE,
        SETUP,
        E_HIGH,
        HOLD,
        GAP,
        WAIT
    } state_t;

    // Timer reload values: a phase of N cycles loads N-1 and exits at 0.
    localparam logic [TW-1:0] LD_AS    = TW'(T_AS - 1);
    localparam logic [TW-1:0] LD_EPW   = TW'(T_EPW - 1);
    localparam logic [TW-1:0] LD_H     = TW'(T_H - 1);
    localparam logic [TW-1:0] LD_NIB   = TW'(T_NIB - 1);
    localparam logic [TW-1:0] LD_EXEC  = TW'(T_EXEC - 1);
    localparam logic [TW-1:0] LD_LONG  = TW'(T_LONG - 1);
    localparam logic [TW-1:0] LD_PWRON = TW'(T_PWRON - 1);
    localparam logic [TW-1:0] LD_INIT2 = TW'(T_INIT2 - 1);
    localparam logic [TW-1:0] LD_INIT3 = TW'(T_INIT3 - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          in_init;     // nibbles come from the init table, not a byte
    logic [1:0]    init_step;   // index of the init nibble in flight
    logic          second_nib;  // low nibble of the latched byte is in flight
    logic          lat_rs;
    logic [7:0]    lat_data;
    logic          long_wait;

    // The LCD write is output-only.
    assign lcd_rw = 1'b0;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    always_comb begin
        long_wait = !lat_rs && (lat_data == 8'h01 || lat_data == 8'h02 || lat_data == 8'h03);
    end

    // Sequencer FSM with phase timer and registered LCD/handshake outputs.
    // NOTE: sequential state uses <= so every register sees pre-edge values; the
    // reset branch is sampled on the clock edge, so rst_n never acts asynchronously.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_db     <= 4'h0;
            second_nib <= 1'b0;
            init_step  <= 2'd0;
            lat_rs     <= 1'b0;
            lat_data   <= 8'h00;
            if (INIT_EN) begin
                state     <= PWR_WAIT;
                timer     <= LD_PWRON;
                in_init   <= 1'b1;
                cmd_ready <= 1'b0;
                init_done <= 1'b0;
                busy      <= 1'b1;
            end else begin
                state     <= IDLE;
                timer     <= '0;
                in_init   <= 1'b0;
                cmd_ready <= 1'b1;
                init_done <= 1'b1;
                busy      <= 1'b0;
            end
        end else begin
            // Count down by default; phase exits below reload the timer.
            if (timer != '0) begin
                timer <= timer - 1'b1;
            end

            case (state)
                PWR_WAIT: begin
                    if (timer == '0) begin
                        state  <= SETUP;
                        timer  <= LD_AS;
                        lcd_rs <= 1'b0;
                        lcd_db <= 4'h3;
                    end
                end

                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        lat_rs     <= cmd_rs;
                        lat_data   <= cmd_data;
                        lcd_rs     <= cmd_rs;
                        lcd_db     <= cmd_data[7:4];
                        second_nib <= 1'b0;
                        state      <= SETUP;
                        timer      <= LD_AS;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                SETUP: begin
                    if (timer == '0) begin
                        state <= E_HIGH;
                        timer <= LD_EPW;
                        lcd_e <= 1'b1;
                    end
                end

                E_HIGH: begin
                    if (timer == '0) begin
                        state <= HOLD;
                        timer <= LD_H;
                        lcd_e <= 1'b0;
                    end
                end

                HOLD: begin
                    if (timer == '0) begin
                        if (in_init) begin
                            state <= WAIT;
                            case (init_step)
                                2'd0:    timer <= LD_INIT2;
                                2'd3:    timer <= LD_EXEC;
                                default: timer <= LD_INIT3;
                            endcase
                        end else if (!second_nib) begin
                            state <= GAP;
                            timer <= LD_NIB;
                        end else begin
                            state <= WAIT;
                            timer <= long_wait ? LD_LONG : LD_EXEC;
                        end
                    end
                end

                GAP: begin
                    if (timer == '0) begin
                        state      <= SETUP;
                        timer      <= LD_AS;
                        second_nib <= 1'b1;
                        lcd_db     <= lat_data[3:0];
                    end
                end

                WAIT: begin
                    if (timer == '0) begin
                        if (in_init && init_step != 2'd3) begin
                            // Init table: 0x3, 0x3, 0x3, then 0x2 switches to 4-bit mode.
                            init_step <= init_step + 2'd1;
                            lcd_db    <= (init_step == 2'd2) ? 4'h2 : 4'h3;
                            state     <= SETUP;
                            timer     <= LD_AS;
                        end else begin
                            state     <= IDLE;
                            in_init   <= 1'b0;
                            init_done <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    timer     <= '0;
                    in_init   <= 1'b0;
                    lcd_e     <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Randomized bench for lcd_hd44780_ctrl: one instance with power-on init and
// one without, driven by the same random traffic and compared every cycle
// against a timeline model of the LCD bus.
module tb_lcd_hd44780_ctrl;

    localparam int T_AS    = 2;
    localparam int T_EPW   = 4;
    localparam int T_H     = 2;
    localparam int T_NIB   = 3;
    localparam int T_EXEC  = 10;
    localparam int T_LONG  = 50;
    localparam int T_PWRON = 100;
    localparam int T_INIT2 = 40;
    localparam int T_INIT3 = 20;
    localparam int TW      = 20;
    localparam int P       = T_AS + T_EPW + T_H;   // one nibble transfer
    localparam int N_CYC   = 4000;

    typedef enum int { M_INIT, M_COLD, M_BYTE } mode_t;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    logic       rdy [2];
    logic       done[2];
    logic       bsy [2];
    logic       e   [2];
    logic       rw  [2];
    logic       rs  [2];
    logic [3:0] db  [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    lcd_hd44780_ctrl #(
        .INIT_EN(1'b1), .T_AS(T_AS), .T_EPW(T_EPW), .T_H(T_H), .T_NIB(T_NIB),
        .T_EXEC(T_EXEC), .T_LONG(T_LONG), .T_PWRON(T_PWRON), .T_INIT2(T_INIT2),
        .T_INIT3(T_INIT3), .TW(TW)
    ) u_dut_init (
        .sys_clk(sys_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
        .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(done[0]), .busy(bsy[0]),
        .lcd_e(e[0]), .lcd_rw(rw[0]), .lcd_rs(rs[0]), .lcd_db(db[0])
    );

    lcd_hd44780_ctrl #(
        .INIT_EN(1'b0), .T_AS(T_AS), .T_EPW(T_EPW), .T_H(T_H), .T_NIB(T_NIB),
        .T_EXEC(T_EXEC), .T_LONG(T_LONG), .T_PWRON(T_PWRON), .T_INIT2(T_INIT2),
        .T_INIT3(T_INIT3), .TW(TW)
    ) u_dut_noinit (
        .sys_clk(sys_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
        .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(done[1]), .busy(bsy[1]),
        .lcd_e(e[1]), .lcd_rw(rw[1]), .lcd_rs(rs[1]), .lcd_db(db[1])
    );

    // Compare one observed value against its expectation and tally the result.
    task automatic check(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {rdy,busy,done,e,rw,rs,db}=%b expected %b", tag, observed, expected);
        end
    endtask

    // E is high in the middle T_EPW cycles of a nibble transfer.
    function automatic logic e_at(input int j);
        return (j >= T_AS) && (j < T_AS + T_EPW);
    endfunction

    // Expected {cmd_ready, busy, init_done, lcd_e, lcd_rw, lcd_rs, lcd_db} for
    // cycle k of the current activity (k = 0 is the cycle after the edge that started it).
    function automatic logic [9:0] model_out(input mode_t mode, input int k,
                                             input logic brs, input logic [7:0] bdat);
        int         j;
        int         w;
        logic [3:0] nb;
        logic [3:0] hi;
        logic [3:0] lo;
        hi = bdat[7:4];
        lo = bdat[3:0];
        case (mode)
            M_COLD: return 10'b1_0_1_0_0_0_0000;
            M_INIT: begin
                if (k < T_PWRON) return 10'b0_1_0_0_0_0_0000;
                j = k - T_PWRON;
                for (int i = 0; i < 4; i++) begin
                    nb = (i == 3) ? 4'h2 : 4'h3;
                    w  = (i == 0) ? T_INIT2 : ((i == 3) ? T_EXEC : T_INIT3);
                    if (j < P) return {3'b010, e_at(j), 2'b00, nb};
                    j -= P;
                    if (j < w) return {3'b010, 1'b0, 2'b00, nb};
                    j -= w;
                end
                return 10'b1_0_1_0_0_0_0010;
            end
            default: begin
                w = (!brs && (bdat == 8'h01 || bdat == 8'h02 || bdat == 8'h03)) ? T_LONG : T_EXEC;
                if (k < P)                 return {3'b011, e_at(k), 1'b0, brs, hi};
                if (k < P + T_NIB)         return {3'b011, 1'b0, 1'b0, brs, hi};
                if (k < 2 * P + T_NIB)     return {3'b011, e_at(k - P - T_NIB), 1'b0, brs, lo};
                if (k < 2 * P + T_NIB + w) return {3'b011, 1'b0, 1'b0, brs, lo};
                return {3'b101, 1'b0, 1'b0, brs, lo};
            end
        endcase
    endfunction

    mode_t      m_mode[2];
    int         m_k   [2];
    logic       m_rs  [2];
    logic [7:0] m_dat [2];

    logic [7:0] pick_tbl [8];

    initial begin
        int         rst_hold;
        bit         did_mid_reset;
        logic [9:0] obs;
        logic [9:0] exp_v;
        string      tag;

        pick_tbl = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h41, 8'h48, 8'hFF};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_rs    = 1'b0;
        cmd_data  = 8'h00;
        rst_hold  = 2;
        did_mid_reset = 1'b0;

        m_mode[0] = M_INIT; m_mode[1] = M_COLD;
        for (int d = 0; d < 2; d++) begin
            m_k[d] = 0; m_rs[d] = 1'b0; m_dat[d] = 8'h00;
        end

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge sys_clk);

            // Compare both instances against the model for this cycle.
            for (int d = 0; d < 2; d++) begin
                obs   = {rdy[d], bsy[d], done[d], e[d], rw[d], rs[d], db[d]};
                exp_v = model_out(m_mode[d], m_k[d], m_rs[d], m_dat[d]);
                tag   = $sformatf("%s cyc%0d", (d == 0) ? "init_en1" : "init_en0", cyc);
                check(tag, obs, exp_v);
            end

            // New inputs for the coming edge; data changes every cycle.
            if (!did_mid_reset && cyc > 1500 && m_mode[0] == M_BYTE && m_k[0] == T_AS + 1) begin
                did_mid_reset = 1'b1;
                rst_hold = 2;
            end
            if (rst_hold > 0) begin
                rst_n = 1'b0;
                rst_hold--;
            end else begin
                rst_n = 1'b1;
            end
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_rs    = $urandom_range(0, 1) == 1;
            cmd_data  = ($urandom_range(0, 1) == 1) ? pick_tbl[$urandom_range(0, 7)]
                                                    : 8'($urandom);

            // Advance the model through the coming edge.
            for (int d = 0; d < 2; d++) begin
                exp_v = model_out(m_mode[d], m_k[d], m_rs[d], m_dat[d]);
                if (!rst_n) begin
                    m_mode[d] = (d == 0) ? M_INIT : M_COLD;
                    m_k[d]    = 0;
                end else if (exp_v[9] && cmd_valid) begin
                    m_mode[d] = M_BYTE;
                    m_k[d]    = 0;
                    m_rs[d]   = cmd_rs;
                    m_dat[d]  = cmd_data;
                end else begin
                    m_k[d]++;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Hardware sequencer for the 4-bit HD44780 character LCD on the board's lcd_e/lcd_rw/lcd_rs/lcd_db[7:4] pins.
- Replaces software bit-banging through the io_lcd register.
- Takes whole command/data bytes from the MCU I/O side over a valid/ready handshake, splits each into two nibbles, and generates E pulses with correct setup, width and hold.
- Enforces execution delays, and runs the power-on 4-bit init sequence autonomously.

Parameters:
- INIT_EN, 1, 1 = run power-on init sequence after reset; 0 = start in IDLE with init_done=1.
- T_AS, 2, cycles rs/db are stable before E rises (≥1).
- T_EPW, 13, cycles E is high (≥450 ns at 27 MHz).
- T_H, 2, cycles rs/db are held after E falls.
- T_NIB, 27, gap cycles between high and low nibble of one byte.
- T_EXEC, 1080, execution wait after a normal byte (40 µs).
- T_LONG, 44550, execution wait after clear/home (1.65 ms).
- T_PWRON, 432000, wait after reset before the first init nibble (16 ms).
- T_INIT2, 118800, wait after the first init nibble (4.4 ms).
- T_INIT3, 2970, wait after the second and third init nibbles (110 µs).
- TW, 20, timer width; must hold the largest T_* minus 1.

Ports:
- sys_clk  in  1  system clock (27 MHz).
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  byte request.
- cmd_ready  out  1  block accepts a byte this cycle.
- cmd_rs  in  1  0 = instruction, 1 = data.
- cmd_data  in  8  byte to send.
- init_done  out  1  init sequence complete (sticky until reset).
- busy  out  1  state != IDLE.
- lcd_e  out  1  LCD enable strobe.
- lcd_rw  out  1  constant 0 (write only).
- lcd_rs  out  1  LCD register select.
- lcd_db  out  4  LCD data nibble, DB7..DB4.

Behaviour:
- One clock: sys_clk. Reset is synchronous, active-low: rst_n sampled low at a sys_clk edge resets everything at that edge.
- All outputs are registered; lcd_rw is tied to 0.
- Reset values:
  - lcd_e=0, lcd_rs=0, lcd_db=0.
  - If INIT_EN=1: cmd_ready=0, init_done=0, busy=1, state PWR_WAIT.
  - If INIT_EN=0: cmd_ready=1, init_done=1, busy=0, state IDLE.
- Timer: loaded with N-1 on entry to a phase of length N; the phase exits when the timer is 0, so every phase lasts exactly N cycles.
- States: PWR_WAIT, IDLE, SETUP, E_HIGH, HOLD, GAP, WAIT.
- Nibble sub-sequence: SETUP(T_AS, e=0, rs/db driven) -> E_HIGH(T_EPW, e=1) -> HOLD(T_H, e=0, rs/db unchanged).
- Init sequence (INIT_EN=1):
  - PWR_WAIT(T_PWRON).
  - Nibble 0x3 (rs=0) -> WAIT T_INIT2.
  - Nibble 0x3 -> WAIT T_INIT3.
  - Nibble 0x3 -> WAIT T_INIT3.
  - Nibble 0x2 -> WAIT T_EXEC.
  - Then IDLE with init_done=1.
  - Total = T_PWRON + 4*(T_AS+T_EPW+T_H) + T_INIT2 + 2*T_INIT3 + T_EXEC cycles.
- cmd_ready=1 only in IDLE.
- Handshake: transfer occurs on a sys_clk edge where cmd_valid & cmd_ready.
  - At that edge cmd_rs/cmd_data are latched, state goes to SETUP with the high nibble, and lcd_rs/lcd_db update.
  - cmd_valid while cmd_ready=0 is ignored; nothing is latched and there is no queue.
- Byte sequence: high nibble -> GAP(T_NIB, e=0) -> low nibble -> WAIT -> IDLE.
- WAIT length is T_LONG if latched rs=0 and data ∈ {0x01, 0x02, 0x03}; otherwise T_EXEC.
- Byte latency: from the acceptance edge to cmd_ready=1 = 2*(T_AS+T_EPW+T_H) + T_NIB + wait.
- Back-to-back: a byte may be accepted in the first IDLE cycle. With cmd_valid held high, cmd_ready is high for exactly 1 cycle per byte.
- lcd_db/lcd_rs never change while lcd_e=1 or during HOLD.
- Reset mid-operation: lcd_e drops at the reset edge and the latched byte is discarded. Init reruns if INIT_EN=1.

Test Plan:
Fast params for all tests: T_AS=2, T_EPW=4, T_H=2, T_NIB=3, T_EXEC=10, T_LONG=50, T_PWRON=100, T_INIT2=40, T_INIT3=20.
1. Init sequence: release reset -> four E pulses with lcd_db=3,3,3,2 and lcd_rs=0; first E rise at cycle 102; init_done=1 and cmd_ready=1 at cycle 222; no cmd accepted before then.
2. Data byte: cmd_valid=1, rs=1, data=0x48 accepted at cycle 0 -> lcd_db=0x4 cycles 0-7 with E high 2-5; lcd_db=0x8 from 11 with E high 13-16; cmd_ready back high at cycle 29.
3. Clear: rs=0, data=0x01 -> WAIT uses 50 cycles, cmd_ready at cycle 69; same bytes with rs=1 -> ready at 29.
4. Handshake: cmd_valid held high with data changing every cycle -> only bytes presented on cmd_ready=1 cycles appear on lcd_db; 3 bytes of 0x41 take 3*29 cycles.
5. Reset mid-pulse: assert rst_n=0 during E_HIGH of a byte -> lcd_e=0 at that edge; after release the init sequence repeats with init_done=0 until cycle 222.
6. INIT_EN=0: after reset, cmd_ready=1 and init_done=1 immediately; a byte of 0xFF shows nibbles F, F and ready returns at 29.
